// File: rtl/survival_timer.sv
// survival_timer: survival-seconds counter with idle/run/pause/over FSM, best-run tracking
// and a free-running segclk for the display multiplexer.
module survival_timer #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int SEG_HZ   = 500,
  parameter int MAX_TIME = 5999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        pause,
  input  logic        dead,
  output logic [15:0] timealive,
  output logic [15:0] best,
  output logic        running,
  output logic        over,
  output logic        segclk
);
  localparam int PW = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;
  localparam int SD = CLK_HZ / (2 * SEG_HZ);
  localparam int SW = $clog2(SD + 1);
  localparam logic [PW-1:0] PTC  = PW'(CLK_HZ - 1);
  localparam logic [SW-1:0] STC  = SW'(SD - 1);
  localparam logic [15:0]   TMAX = 16'(MAX_TIME);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, OVER} state_t;
  state_t        state, nxt;
  logic [PW-1:0] pre, pre_nxt;
  logic [15:0]   ta_nxt, best_nxt;
  logic [SW-1:0] div;
  logic          tc;
  assign tc = pre == PTC;
  always_comb begin
    nxt      = state;
    pre_nxt  = pre;
    ta_nxt   = timealive;
    best_nxt = best;
    case (state)
      IDLE, OVER: if (start) begin
        nxt     = RUN;
        pre_nxt = '0;
        ta_nxt  = '0;
      end
      RUN: if (dead) begin
        nxt      = OVER;
        best_nxt = timealive > best ? timealive : best;
      end else if (pause) begin
        nxt = PAUSE;
      end else begin
        pre_nxt = tc ? '0 : pre + 1'b1;
        ta_nxt  = (tc && timealive < TMAX) ? timealive + 16'd1 : timealive;
      end
      PAUSE: if (dead) begin
        nxt      = OVER;
        best_nxt = timealive > best ? timealive : best;
      end else if (pause) begin
        nxt = RUN;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pre       <= '0;
      timealive <= '0;
      best      <= '0;
      running   <= 1'b0;
      over      <= 1'b0;
    end else begin
      state     <= nxt;
      pre       <= pre_nxt;
      timealive <= ta_nxt;
      best      <= best_nxt;
      running   <= nxt == RUN;
      over      <= nxt == OVER;
    end
  end
  // Display refresh keeps running regardless of game state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div    <= '0;
      segclk <= 1'b0;
    end else begin
      div    <= div == STC ? '0 : div + 1'b1;
      segclk <= div == STC ? ~segclk : segclk;
    end
  end
endmodule

// File: tb/tb_survival_timer.sv
// tb_survival_timer: directed test-plan scenarios plus random pulses, checked against a
// tick-counting reference model.
module tb_survival_timer;
  localparam int CLK_HZ = 10, SEG_HZ = 1, MAX_TIME = 5;
  localparam int SD = CLK_HZ / (2 * SEG_HZ);
  logic clk = 0, rst_n = 0, start = 0, pause = 0, dead = 0;
  logic [15:0] timealive, best;
  logic running, over, segclk;
  int vectors = 0, errors = 0;
  int m_st = 0, m_ticks = 0, m_best = 0, m_cyc = 0;
  survival_timer #(.CLK_HZ(CLK_HZ), .SEG_HZ(SEG_HZ), .MAX_TIME(MAX_TIME)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .dead(dead),
    .timealive(timealive), .best(best), .running(running), .over(over), .segclk(segclk)
  );
  always #5 clk = ~clk;
  function automatic int m_ta();
    return (m_ticks / CLK_HZ) > MAX_TIME ? MAX_TIME : m_ticks / CLK_HZ;
  endfunction
  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_all();
    check("timealive", int'(timealive), m_ta());
    check("best", int'(best), m_best);
    check("running", int'(running), int'(m_st == 1));
    check("over", int'(over), int'(m_st == 3));
    check("segclk", int'(segclk), (m_cyc / SD) % 2);
  endtask
  task automatic m_reset();
    m_st = 0; m_ticks = 0; m_best = 0; m_cyc = 0;
  endtask
  // states: 0 idle, 1 run, 2 pause, 3 over
  task automatic m_edge(input logic s, input logic p, input logic d);
    m_cyc++;
    if (m_st == 0 || m_st == 3) begin
      if (s) begin m_st = 1; m_ticks = 0; end
    end else if (d) begin
      if (m_ta() > m_best) m_best = m_ta();
      m_st = 3;
    end else if (p) begin
      m_st = m_st == 1 ? 2 : 1;
    end else if (m_st == 1) begin
      m_ticks++;
    end
  endtask
  task automatic step(input logic s, input logic p, input logic d);
    start = s; pause = p; dead = d;
    @(posedge clk);
    m_edge(s, p, d);
    #1;
    start = 0; pause = 0; dead = 0;
    check_all();
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask
  initial begin
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1;
    idle(12);
    step(1, 0, 0);
    idle(35);
    check("run35_running", int'(running), 1);
    step(1, 0, 0);
    idle(12);
    step(0, 1, 0);
    idle(6);
    check("paused_running", int'(running), 0);
    step(0, 1, 0);
    idle(20);
    step(1, 0, 0);
    idle(80);
    check("saturated", int'(timealive), MAX_TIME);
    step(0, 0, 1);
    step(1, 0, 0);
    idle(29);
    step(0, 0, 1);
    check("dead_tc_ta", int'(timealive), 2);
    m_reset();
    // Force best back to a known 2 via reset + rerun, then verify a shorter run keeps it.
    #2 rst_n = 0;
    #1 check_all();
    @(negedge clk);
    rst_n = 1;
    step(1, 0, 0);
    idle(29);
    step(0, 0, 1);
    check("best_two", int'(best), 2);
    idle(3);
    step(1, 0, 0);
    idle(10);
    step(0, 0, 1);
    check("best_keep", int'(best), 2);
    step(1, 0, 0);
    idle(13);
    #2 rst_n = 0;
    m_reset();
    #1 check_all();
    check("async_running", int'(running), 0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 39) == 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/survival_timer.md
# survival_timer

Upstream time source for the seven-segment score display. It counts whole seconds of player survival as a 16-bit `timealive` value, runs a small game-state machine (idle / running / paused / over), and tracks the best run since reset. It also generates the free-running `segclk` square wave that clocks the display digit multiplexer. Both `timealive` and `segclk` connect directly to the display block.

## Interface
- `CLK_HZ`, default 100_000_000: input clock frequency; one second is this many `clk` cycles.
- `SEG_HZ`, default 500: `segclk` frequency. `CLK_HZ` must be divisible by 2*`SEG_HZ`.
- `MAX_TIME`, default 5999: saturation value for `timealive`, i.e. 99:59 on the display.

Ports:
- `clk` in 1: system clock; all state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: one-cycle pulse; begins a new run from IDLE or OVER.
- `pause` in 1: one-cycle pulse; toggles between RUN and PAUSE.
- `dead` in 1: one-cycle pulse; ends the current run.
- `timealive` out 16: seconds survived in the current or last run.
- `best` out 16: largest final `timealive` of any run since reset.
- `running` out 1: high in RUN.
- `over` out 1: high in OVER.
- `segclk` out 1: registered square wave at `SEG_HZ`, driven to the display.

## Operation
- States: IDLE, RUN, PAUSE, OVER. Reset state is IDLE.
- Reset values: `timealive`=0, `best`=0, `running`=0, `over`=0, `segclk`=0, prescaler=0, seg divider=0.
- IDLE:
  - `start` moves to RUN, clears `timealive` to 0 and the prescaler to 0.
  - `pause` and `dead` are ignored.
- RUN:
  - `dead` moves to OVER.
  - Otherwise `pause` moves to PAUSE.
  - Otherwise the prescaler advances (see Timing).
  - `start` is ignored.
- PAUSE:
  - `dead` moves to OVER; `pause` moves back to RUN.
  - The prescaler holds its value, so the partial second is preserved.
  - `timealive` holds. `start` is ignored.
- OVER:
  - `timealive` holds its final value.
  - `start` moves to RUN with the same clears as from IDLE.
  - `pause` and `dead` are ignored.
- Priority within one cycle: `dead` > `pause`. `start` is only decoded in IDLE and OVER, so it never conflicts with the other two.
- `best` update:
  - Occurs on the edge where `dead` is accepted (from RUN or PAUSE).
  - If `timealive` > `best`, then `best` <= `timealive`, using the pre-edge value.
  - `best` is never cleared except by reset.
- Arithmetic:
  - `timealive` increments by 1 per second and saturates at `MAX_TIME`; it never wraps.
  - Prescaler width is clog2(`CLK_HZ`).
- `segclk`:
  - A divider counts 0..`CLK_HZ`/(2*`SEG_HZ`)-1 and toggles `segclk` at terminal count.
  - Runs in every state, including IDLE and OVER, because the display must keep refreshing.
  - Unaffected by `start`, `pause` or `dead`.
- `running` and `over` are registered decodes of the next state; they change on the same edge as the state.

## Timing
- `start` sampled at edge k: state=RUN and `timealive`=0 after edge k.
- RUN edges:
  - If prescaler == `CLK_HZ`-1, the prescaler goes to 0 and `timealive` increments.
  - Otherwise the prescaler increments.
- First increment latency: `timealive`=1 after edge k+`CLK_HZ`; thereafter +1 every `CLK_HZ` RUN cycles.
- PAUSE cycles do not count toward the second. A run paused for P cycles reaches 1 at edge k+`CLK_HZ`+P.
- `dead` arriving on the same edge as a prescaler terminal count: `dead` wins, no increment, and `best` compares the un-incremented value.
- At saturation: prescaler keeps cycling; `timealive` stays at `MAX_TIME`.
- `segclk` period is exactly `CLK_HZ`/`SEG_HZ` cycles with 50% duty. First rise occurs after edge `CLK_HZ`/(2*`SEG_HZ`) following reset release.
- Reset asserted mid-run: all outputs and counters return to reset values immediately, without waiting for a clock edge. Operation resumes in IDLE on the first edge after release.

## Test plan
All scenarios use `CLK_HZ`=10, `SEG_HZ`=1, `MAX_TIME`=5.
- Reset, then free-run: `segclk`=0, toggles every 5 cycles; `timealive`=0, `best`=0, state IDLE, both flags 0.
- `start` at edge 0, run 35 cycles: `timealive` reaches 1, 2, 3 after edges 10, 20, 30; `running`=1 throughout.
- Run 12 cycles, `pause` for 7 cycles, `pause` again: `timealive` reaches 2 at edge 27, not edge 20; `running`=0 during PAUSE.
- Run 80 cycles: `timealive` saturates at 5 from edge 50 onward, with no wrap.
- `dead` on edge 30, coincident with a terminal count: `over`=1, `timealive`=2, `best`=2.
- After OVER, `start` then `dead` at `timealive`=1: `best` stays 2. Assert `rst_n`=0 mid-run: all outputs clear asynchronously.
